// File: rtl/usr_serdes_pkg.sv
// Shared types and helpers for the universal shift register / framing controller.
package usr_serdes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TX   = 2'b01,
        ST_RX   = 2'b10
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // A one-bit counter is the floor so that WIDTH=2 still has a usable counter.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/usr_shift_core.sv
// WIDTH-bit shift register with parallel load, serial input and selectable direction.
module usr_shift_core
    import usr_serdes_pkg::*;
#(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_en_i,
    input  logic             dir_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    // Load wins over shift; the caller zero-fills by driving ser_i low.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_en_i) begin
            if (dir_i == DIR_RIGHT) begin
                data_q <= {ser_i, data_q[WIDTH-1:1]};
            end else begin
                data_q <= {data_q[WIDTH-2:0], ser_i};
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/usr_serdes_frame.sv
// Framing controller: moves a WIDTH-bit word between parallel and serial form
// in either direction, with valid/ready handshakes on the TX side.
module usr_serdes_frame
    import usr_serdes_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             abort,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             ser_out,
    output logic             ser_out_valid,
    input  logic             ser_out_ready,
    output logic             tx_done,
    input  logic             rx_start,
    input  logic             ser_in,
    input  logic             ser_in_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic [WIDTH-1:0] data_out
);

    localparam int            CW        = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic          SHIFT_DIR = LSB_FIRST ? DIR_RIGHT : DIR_LEFT;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             tx_done_q;
    logic             rx_valid_q;
    logic [WIDTH-1:0] storage_q;
    logic [WIDTH-1:0] rx_word_d;

    logic is_idle;
    logic is_tx;
    logic is_rx;
    logic tx_accept;
    logic tx_step;
    logic rx_step;
    logic core_ser;

    assign is_idle = (state_q == ST_IDLE);
    assign is_tx   = (state_q == ST_TX);
    assign is_rx   = (state_q == ST_RX);

    assign tx_ready  = is_idle && !abort;
    assign tx_accept = tx_ready && tx_valid;
    assign tx_step   = is_tx && !abort && ser_out_ready;
    assign rx_step   = is_rx && !abort && ser_in_valid;
    assign core_ser  = is_rx ? ser_in : 1'b0;

    // The word as it will look once the current serial bit lands, so the
    // final bit of a frame can be published on the same edge it is shifted in.
    assign rx_word_d = LSB_FIRST ? {ser_in, storage_q[WIDTH-1:1]}
                                 : {storage_q[WIDTH-2:0], ser_in};

    usr_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .RST         (RST),
        .load_i      (tx_accept),
        .load_data_i (tx_data),
        .shift_en_i  (tx_step || rx_step),
        .dir_i       (SHIFT_DIR),
        .ser_i       (core_ser),
        .data_o      (storage_q)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (tx_valid) begin
                            state_q <= ST_TX;
                            cnt_q   <= '0;
                        end else if (rx_start) begin
                            state_q <= ST_RX;
                            cnt_q   <= '0;
                        end
                    end
                    ST_TX: begin
                        if (ser_out_ready) begin
                            if (cnt_q == LAST_BIT) begin
                                state_q   <= ST_IDLE;
                                cnt_q     <= '0;
                                tx_done_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    ST_RX: begin
                        if (ser_in_valid) begin
                            if (cnt_q == LAST_BIT) begin
                                state_q    <= ST_IDLE;
                                cnt_q      <= '0;
                                rx_data_q  <= rx_word_d;
                                rx_valid_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign ser_out_valid = is_tx;
    assign ser_out       = is_tx && (LSB_FIRST ? storage_q[0] : storage_q[WIDTH-1]);
    assign tx_done       = tx_done_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign busy          = !is_idle;
    assign data_out      = storage_q;

endmodule

// File: tb/tb_usr_serdes_frame.sv
// Directed bench for usr_serdes_frame: LSB/MSB-first framing, stalls, gaps,
// priority, abort, async reset, and WIDTH=2 / WIDTH=64 loopback.
module tb_usr_serdes_frame;

    logic clk = 1'b0;
    bit   clkRun = 1'b1;
    logic RST;

    int vectors = 0;
    int miscompares = 0;

    // Main instance: WIDTH=15, LSB first
    logic        abort, txValid, txReady, serOut, serOutValid, serOutReady, txDone;
    logic        rxStart, serIn, serInValid, rxValid, busy;
    logic [14:0] txData, rxData, dataOut;

    // MSB-first instance
    logic        mTxValid, mTxReady, mSerOut, mSerOutValid, mSerOutReady, mTxDone;
    logic        mRxStart, mSerIn, mSerInValid, mRxValid, mBusy;
    logic [14:0] mTxData, mRxData, mDataOut;

    // WIDTH=2 instance
    logic        nTxValid, nTxReady, nSerOut, nSerOutValid, nSerOutReady, nTxDone;
    logic        nRxStart, nSerIn, nSerInValid, nRxValid, nBusy;
    logic [1:0]  nTxData, nRxData, nDataOut;

    // WIDTH=64 instance
    logic        wTxValid, wTxReady, wSerOut, wSerOutValid, wSerOutReady, wTxDone;
    logic        wRxStart, wSerIn, wSerInValid, wRxValid, wBusy;
    logic [63:0] wTxData, wRxData, wDataOut;

    logic [14:0] seqLsb = 15'b101101000111100;
    logic [14:0] seqMsb = 15'b001111000101101;
    logic [1:0]  cap2;
    logic [63:0] cap64;
    int          idx;
    int          stall;

    usr_serdes_frame #(.WIDTH(15), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .RST(RST), .abort(abort),
        .tx_valid(txValid), .tx_ready(txReady), .tx_data(txData),
        .ser_out(serOut), .ser_out_valid(serOutValid), .ser_out_ready(serOutReady),
        .tx_done(txDone), .rx_start(rxStart), .ser_in(serIn), .ser_in_valid(serInValid),
        .rx_data(rxData), .rx_valid(rxValid), .busy(busy), .data_out(dataOut)
    );

    usr_serdes_frame #(.WIDTH(15), .LSB_FIRST(1'b0)) dutM (
        .clk(clk), .RST(RST), .abort(1'b0),
        .tx_valid(mTxValid), .tx_ready(mTxReady), .tx_data(mTxData),
        .ser_out(mSerOut), .ser_out_valid(mSerOutValid), .ser_out_ready(mSerOutReady),
        .tx_done(mTxDone), .rx_start(mRxStart), .ser_in(mSerIn), .ser_in_valid(mSerInValid),
        .rx_data(mRxData), .rx_valid(mRxValid), .busy(mBusy), .data_out(mDataOut)
    );

    usr_serdes_frame #(.WIDTH(2), .LSB_FIRST(1'b1)) dut2 (
        .clk(clk), .RST(RST), .abort(1'b0),
        .tx_valid(nTxValid), .tx_ready(nTxReady), .tx_data(nTxData),
        .ser_out(nSerOut), .ser_out_valid(nSerOutValid), .ser_out_ready(nSerOutReady),
        .tx_done(nTxDone), .rx_start(nRxStart), .ser_in(nSerIn), .ser_in_valid(nSerInValid),
        .rx_data(nRxData), .rx_valid(nRxValid), .busy(nBusy), .data_out(nDataOut)
    );

    usr_serdes_frame #(.WIDTH(64), .LSB_FIRST(1'b1)) dut64 (
        .clk(clk), .RST(RST), .abort(1'b0),
        .tx_valid(wTxValid), .tx_ready(wTxReady), .tx_data(wTxData),
        .ser_out(wSerOut), .ser_out_valid(wSerOutValid), .ser_out_ready(wSerOutReady),
        .tx_done(wTxDone), .rx_start(wRxStart), .ser_in(wSerIn), .ser_in_valid(wSerInValid),
        .rx_data(wRxData), .rx_valid(wRxValid), .busy(wBusy), .data_out(wDataOut)
    );

    // Free-running clock that can be frozen to observe asynchronous reset.
    always begin
        #5;
        if (clkRun) clk = ~clk;
    end

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b0;
        {abort, txValid, serOutReady, rxStart, serIn, serInValid} = '0;
        txData = '0;
        {mTxValid, mSerOutReady, mRxStart, mSerIn, mSerInValid} = '0;
        mTxData = '0;
        {nTxValid, nSerOutReady, nRxStart, nSerIn, nSerInValid} = '0;
        nTxData = '0;
        {wTxValid, wSerOutReady, wRxStart, wSerIn, wSerInValid} = '0;
        wTxData = '0;

        // Reset state
        #2;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst tx_ready", txReady, 1);
        checkOutput("rst ser_out_valid", serOutValid, 0);
        checkOutput("rst data_out", dataOut, 0);
        checkOutput("rst rx_data", rxData, 0);
        checkOutput("rst rx_valid", rxValid, 0);
        checkOutput("rst tx_done", txDone, 0);
        #10;
        RST = 1'b1;
        applyStimulus(1);

        // 1: plain LSB-first transmit
        txData = 15'h5A3C; txValid = 1'b1; serOutReady = 1'b1;
        #1;
        checkOutput("t1 tx_ready idle", txReady, 1);
        applyStimulus(1);
        txValid = 1'b0; txData = '0;
        for (int i = 0; i < 15; i++) begin
            checkOutput("t1 ser_out_valid", serOutValid, 1);
            checkOutput("t1 ser_out", serOut, seqLsb[i]);
            checkOutput("t1 tx_ready", txReady, 0);
            checkOutput("t1 tx_done early", txDone, 0);
            applyStimulus(1);
        end
        checkOutput("t1 tx_done", txDone, 1);
        checkOutput("t1 ser_out_valid end", serOutValid, 0);
        checkOutput("t1 tx_ready end", txReady, 1);
        applyStimulus(1);
        checkOutput("t1 tx_done pulse", txDone, 0);

        // 2: same word with two-cycle stalls on bits 3 and 9
        txData = 15'h5A3C; txValid = 1'b1; serOutReady = 1'b1;
        applyStimulus(1);
        txValid = 1'b0;
        idx = 0; stall = 0;
        for (int c = 0; c < 19; c++) begin
            if ((idx == 3 || idx == 9) && stall < 2) begin
                serOutReady = 1'b0; stall++;
            end else begin
                serOutReady = 1'b1;
            end
            #1;
            checkOutput("t2 ser_out_valid", serOutValid, 1);
            checkOutput("t2 ser_out", serOut, seqLsb[idx]);
            checkOutput("t2 tx_done early", txDone, 0);
            applyStimulus(1);
            if (serOutReady) begin idx++; stall = 0; end
        end
        checkOutput("t2 tx_done", txDone, 1);
        checkOutput("t2 ser_out_valid end", serOutValid, 0);
        serOutReady = 1'b0;

        // 3a: LSB-first receive with alternating gaps
        rxStart = 1'b1;
        applyStimulus(1);
        rxStart = 1'b0;
        checkOutput("t3 busy", busy, 1);
        checkOutput("t3 tx_ready", txReady, 0);
        for (int i = 0; i < 15; i++) begin
            serIn = seqLsb[i]; serInValid = 1'b1;
            applyStimulus(1);
            serInValid = 1'b0; serIn = ~seqLsb[i];
            if (i < 14) begin
                checkOutput("t3 rx_valid early", rxValid, 0);
                applyStimulus(1);
            end
        end
        checkOutput("t3 rx_valid", rxValid, 1);
        checkOutput("t3 rx_data", rxData, 15'h5A3C);
        checkOutput("t3 busy end", busy, 0);
        applyStimulus(1);
        checkOutput("t3 rx_valid pulse", rxValid, 0);
        checkOutput("t3 rx_data held", rxData, 15'h5A3C);

        // 3b: MSB-first transmit then receive
        mTxData = 15'h5A3C; mTxValid = 1'b1; mSerOutReady = 1'b1;
        applyStimulus(1);
        mTxValid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            checkOutput("t3m ser_out", mSerOut, seqMsb[i]);
            applyStimulus(1);
        end
        checkOutput("t3m tx_done", mTxDone, 1);
        mRxStart = 1'b1;
        applyStimulus(1);
        mRxStart = 1'b0;
        for (int i = 0; i < 15; i++) begin
            mSerIn = seqMsb[i]; mSerInValid = 1'b1;
            applyStimulus(1);
            mSerInValid = 1'b0; mSerIn = ~seqMsb[i];
            if (i < 14) applyStimulus(1);
        end
        checkOutput("t3m rx_valid", mRxValid, 1);
        checkOutput("t3m rx_data", mRxData, 15'h5A3C);

        // 4: tx_valid and rx_start together -> TX only
        txData = 15'h1234; txValid = 1'b1; rxStart = 1'b1; serOutReady = 1'b1;
        applyStimulus(1);
        txValid = 1'b0; rxStart = 1'b0;
        checkOutput("t4 busy", busy, 1);
        checkOutput("t4 ser_out_valid", serOutValid, 1);
        serIn = 1'b1; serInValid = 1'b1;
        applyStimulus(15);
        checkOutput("t4 tx_done", txDone, 1);
        checkOutput("t4 busy end", busy, 0);
        checkOutput("t4 data_out drained", dataOut, 0);
        applyStimulus(20);
        checkOutput("t4 rx_valid", rxValid, 0);
        checkOutput("t4 rx_data kept", rxData, 15'h5A3C);
        checkOutput("t4 data_out idle", dataOut, 0);
        serInValid = 1'b0; serIn = 1'b0;

        // 5a: abort on TX bit 7
        txData = 15'h5A3C; txValid = 1'b1; serOutReady = 1'b1;
        applyStimulus(1);
        txValid = 1'b0;
        applyStimulus(7);
        checkOutput("t5 bit7", serOut, seqLsb[7]);
        abort = 1'b1;
        #1;
        checkOutput("t5 tx_ready abort", txReady, 0);
        applyStimulus(1);
        abort = 1'b0;
        #1;
        checkOutput("t5 busy", busy, 0);
        checkOutput("t5 tx_done", txDone, 0);
        checkOutput("t5 tx_ready", txReady, 1);
        checkOutput("t5 ser_out_valid", serOutValid, 0);
        checkOutput("t5 storage held", dataOut, 15'h00B4);
        applyStimulus(1);
        checkOutput("t5 tx_done late", txDone, 0);

        // 5b: async reset on RX bit 10 with the clock frozen
        rxStart = 1'b1;
        applyStimulus(1);
        rxStart = 1'b0;
        for (int i = 0; i < 10; i++) begin
            serIn = (i % 2 == 0); serInValid = 1'b1;
            applyStimulus(1);
        end
        serIn = 1'b1;
        clkRun = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        checkOutput("t5 rst busy", busy, 0);
        checkOutput("t5 rst data_out", dataOut, 0);
        checkOutput("t5 rst rx_data", rxData, 0);
        checkOutput("t5 rst rx_valid", rxValid, 0);
        #20;
        checkOutput("t5 rst hold data_out", dataOut, 0);
        serInValid = 1'b0;
        RST = 1'b1;
        #2;
        clkRun = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("t5 post rst rx_valid", rxValid, 0);
            checkOutput("t5 post rst busy", busy, 0);
        end

        // 6a: WIDTH=2 loopback
        nTxData = 2'b10; nTxValid = 1'b1; nSerOutReady = 1'b1;
        applyStimulus(1);
        nTxValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("t6 w2 ser_out_valid", nSerOutValid, 1);
            checkOutput("t6 w2 ser_out", nSerOut, i % 2);
            cap2[i] = nSerOut;
            applyStimulus(1);
        end
        checkOutput("t6 w2 tx_done", nTxDone, 1);
        checkOutput("t6 w2 busy", nBusy, 0);
        nRxStart = 1'b1;
        applyStimulus(1);
        nRxStart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nSerIn = cap2[i]; nSerInValid = 1'b1;
            applyStimulus(1);
        end
        nSerInValid = 1'b0;
        checkOutput("t6 w2 rx_valid", nRxValid, 1);
        checkOutput("t6 w2 rx_data", nRxData, 2'b10);

        // 6b: WIDTH=64 loopback
        wTxData = 64'hAAAA_AAAA_AAAA_AAAA; wTxValid = 1'b1; wSerOutReady = 1'b1;
        applyStimulus(1);
        wTxValid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            checkOutput("t6 w64 ser_out", wSerOut, i % 2);
            checkOutput("t6 w64 tx_done early", wTxDone, 0);
            cap64[i] = wSerOut;
            applyStimulus(1);
        end
        checkOutput("t6 w64 tx_done", wTxDone, 1);
        checkOutput("t6 w64 busy", wBusy, 0);
        wRxStart = 1'b1;
        applyStimulus(1);
        wRxStart = 1'b0;
        for (int i = 0; i < 64; i++) begin
            wSerIn = cap64[i]; wSerInValid = 1'b1;
            applyStimulus(1);
            if (i < 63) checkOutput("t6 w64 rx_valid early", wRxValid, 0);
        end
        wSerInValid = 1'b0;
        checkOutput("t6 w64 rx_valid", wRxValid, 1);
        checkOutput("t6 w64 rx_data", wRxData, 64'hAAAA_AAAA_AAAA_AAAA);
        checkOutput("t6 w64 busy end", wBusy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usr_serdes_frame.md
Name: usr_serdes_frame

Overview:
Parametrised universal shift register with a framing controller, used to move Hamming codewords between parallel and serial form.
- TX: accepts a parallel word over a valid/ready handshake and shifts it out one bit per accepted serial slot, with back-pressure.
- RX: collects WIDTH serial bits, tolerating gaps, and presents the assembled word with a one-cycle valid pulse.
- Shift order is selectable. A bit counter and a 3-state FSM replace free-running shift/load control.

Parameters:
WIDTH, 15, codeword width in bits; legal range 2..64.
LSB_FIRST, 1, 1 = serial I/O is LSB first (serial-in enters at the MSB, shifting right); 0 = MSB first (serial-in enters at the LSB, shifting left).

Ports:
clk  in  1  single clock; all state changes on the rising edge.
RST  in  1  reset, asynchronous, active-low; clears all state immediately.
abort  in  1  synchronous return to IDLE; discards any partial frame.
tx_valid  in  1  parallel word offered.
tx_ready  out  1  block accepts a word this cycle.
tx_data  in  WIDTH  word to serialise.
ser_out  out  1  serial TX bit.
ser_out_valid  out  1  ser_out is meaningful.
ser_out_ready  in  1  sink takes ser_out this cycle.
tx_done  out  1  one-cycle pulse after the last TX bit is taken.
rx_start  in  1  begin collecting a frame (IDLE only).
ser_in  in  1  serial RX bit.
ser_in_valid  in  1  ser_in is meaningful this cycle.
rx_data  out  WIDTH  assembled word.
rx_valid  out  1  one-cycle pulse; rx_data valid in that cycle.
busy  out  1  state != IDLE.
data_out  out  WIDTH  raw shift-register contents.

Behaviour:
- Reset (RST=0, async): storage=0, bit counter=0, state=IDLE, rx_data=0, tx_done=0, rx_valid=0.
  - Reset mid-frame aborts silently; no done/valid pulse.
- States: IDLE, TX, RX. Encoded 2'b00/01/10.
  - Illegal encoding returns to IDLE on the next edge.
- Priority on every edge: abort > TX acceptance > rx_start.
- abort=1: state<=IDLE, counter<=0. Storage is held. No pulses are generated, even if the last bit coincides.
- IDLE:
  - tx_ready = 1 when abort=0. tx_ready = 0 in TX and RX.
  - If tx_valid: storage<=tx_data, counter<=0, state<=TX.
  - Else if rx_start: counter<=0, state<=RX.
  - tx_valid and rx_start in the same cycle: TX wins; rx_start is ignored, not queued.
- TX:
  - ser_out_valid=1. ser_out = storage[0] when LSB_FIRST, else storage[WIDTH-1]. ser_out is combinational from storage.
  - On ser_out_ready=1: shift storage by one, zero-fill, toward the output end; counter++.
  - ser_out_ready=0: storage and counter hold (stall; no limit on stall length).
  - When counter==WIDTH-1 and ser_out_ready=1: state<=IDLE, tx_done<=1 for one cycle.
  - With no stalls, ser_out_valid is high for exactly WIDTH consecutive cycles starting the cycle after acceptance.
  - A new tx_valid is accepted in the tx_done cycle at the earliest.
- RX:
  - On ser_in_valid=1: LSB_FIRST storage<={ser_in, storage[WIDTH-1:1]}; else storage<={storage[WIDTH-2:0], ser_in}. counter++.
  - On the WIDTH-th valid bit: rx_data<=assembled word (including that bit), rx_valid<=1 next cycle for one cycle, state<=IDLE.
  - ser_in_valid gaps of any length are allowed.
  - ser_in_valid is ignored outside RX.
- ser_out_valid=0 and ser_out=0 outside TX.
- rx_data is held until the next completed frame.
- Counter is $clog2(WIDTH) bits. It never exceeds WIDTH-1; wrap is prevented by the state exit.
- Latency: TX word to first bit = 1 cycle. RX last bit to rx_valid = 1 cycle.

Decomposition:
- Package usr_serdes_pkg holds:
  - state enum (ST_IDLE, ST_TX, ST_RX);
  - shift-direction constants (DIR_RIGHT, DIR_LEFT);
  - function cnt_w(WIDTH) returning the counter width.
- Sub-module usr_shift_core: WIDTH-bit register with async active-low clear, load, shift enable, direction, serial in and zero-fill.
- The FSM, counter and handshakes stay in usr_serdes_frame.

Test Plan:
1. WIDTH=15, LSB_FIRST=1; tx_data=15'h5A3C, tx_valid one cycle, ser_out_ready=1 -> ser_out = 0,0,1,1,1,1,0,0,0,1,0,1,1,0,1 on 15 consecutive cycles; tx_done pulses once; tx_ready=0 throughout.
2. Same word with ser_out_ready low on bits 3 and 9 for 2 cycles each -> identical bit sequence, 19 valid cycles, no bit duplicated or dropped.
3. rx_start, then feed the scenario-1 sequence with ser_in_valid toggling 1/0 -> rx_valid pulse one cycle after the 15th bit, rx_data=15'h5A3C. Repeat with LSB_FIRST=0, MSB first -> same word.
4. tx_valid and rx_start asserted together in IDLE -> TX frame runs; no RX entry; a following ser_in stream leaves rx_data unchanged.
5. abort on TX bit 7, then RST low on RX bit 10 of a new frame -> no tx_done or rx_valid. After abort: IDLE, tx_ready=1 next cycle. After RST: immediate IDLE with storage=0 while clk is stopped.
6. WIDTH=2 and WIDTH=64 frames of alternating bits -> correct round trip through a TX-to-RX loopback, counter never exceeds WIDTH-1.
